wb_result_sel_pipe: RTL and testbench

- Parametrised, registered successor to the writeback result multiplexer.
- Selects one of NUM_IN result sources of WIDTH bits and carries rd/reg_write alongside.
- Registers the choice into a two-entry skid-buffered output stage with valid/ready handshake, so writeback can be back-pressured without a combinational ready path.
- Sits between the MEM/WB pipeline register and the register file write port; the hazard unit drives flush.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_skid_buf.sv | 79 +++++++
 rtl/wb_result_sel_pipe.sv | 108 ++++++++++
 tb/tb_wb_result_sel_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
//------------------------------------------------------------------------------
// wb_pkg
// Shared writeback constants: result-source indices, default widths, bundle type.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

    localparam int WB_WIDTH = 32;
    localparam int WB_RD_W  = 5;

    localparam int RESULT_SEL_ALU    = 0;
    localparam int RESULT_SEL_MEM    = 1;
    localparam int RESULT_SEL_PC4    = 2;
    localparam int RESULT_SEL_IMM    = 3;
    localparam int RESULT_SEL_AUIPC  = 4;
    localparam int RESULT_SEL_CSR    = 5;
    localparam int RESULT_SEL_MULDIV = 6;
    localparam int RESULT_SEL_RSVD   = 7;

    typedef struct packed {
        logic [WB_WIDTH-1:0] data;
        logic [WB_RD_W-1:0]  rd;
        logic                we;
    } wb_bundle_t;

endpackage

`default_nettype wire

// File: rtl/wb_skid_buf.sv
//------------------------------------------------------------------------------
// wb_skid_buf
// Two-entry valid/ready buffer; in_ready depends only on registered state.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_skid_buf #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_bits,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_bits
);

    logic         m_valid_q, m_valid_d;
    logic         s_valid_q, s_valid_d;
    logic [W-1:0] m_bits_q,  m_bits_d;
    logic [W-1:0] s_bits_q,  s_bits_d;
    logic         accept;
    logic         drain;

    assign in_ready  = !s_valid_q;
    assign accept    = in_valid && in_ready;
    assign drain     = m_valid_q && out_ready;
    assign out_valid = m_valid_q;
    assign out_bits  = m_bits_q;

    always_comb begin
        m_valid_d = m_valid_q;
        m_bits_d  = m_bits_q;
        s_valid_d = s_valid_q;
        s_bits_d  = s_bits_q;
        if (s_valid_q) begin
            if (drain) begin
                m_bits_d  = s_bits_q;
                s_valid_d = 1'b0;
            end
        end else if (!m_valid_q || drain) begin
            if (accept) begin
                m_valid_d = 1'b1;
                m_bits_d  = in_bits;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_bits_d  = in_bits;
        end
        // Flush drops entries but leaves the payload visible on the outputs.
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_bits_q  <= '0;
            s_bits_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_bits_q  <= m_bits_d;
            s_bits_q  <= s_bits_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_result_sel_pipe.sv
//------------------------------------------------------------------------------
// wb_result_sel_pipe
// Registered writeback result select feeding a skid-buffered output stage.
// Option macro WB_RESULT_SEL_ERR_EN: sticky sel_err on out-of-range select.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_result_sel_pipe
    import wb_pkg::*;
#(
    parameter  int WIDTH  = WB_WIDTH,
    parameter  int NUM_IN = 8,
    parameter  int RD_W   = WB_RD_W,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [RD_W-1:0]         in_rd,
    input  logic                    in_we,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [RD_W-1:0]         out_rd,
    output logic                    out_we,
    output logic                    sel_err
);

    localparam int BW = WIDTH + RD_W + 1;

    logic [WIDTH-1:0] sel_val;
    logic             bundle_we;
    logic [BW-1:0]    in_bits;
    logic [BW-1:0]    out_bits;
    logic             buf_valid;

    // Unmatched select values (only possible for non-power-of-2 NUM_IN) yield zero.
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_val = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef WB_RESULT_SEL_ERR_EN
    logic in_range;
    logic sel_err_q, sel_err_d;

    always_comb begin
        in_range = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                in_range = 1'b1;
            end
        end
    end

    assign bundle_we = in_we & in_range;

    always_comb begin
        sel_err_d = sel_err_q | (in_valid & in_ready & ~in_range);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign bundle_we = in_we;
    assign sel_err   = 1'b0;
`endif

    assign in_bits = {sel_val, in_rd, bundle_we};

    wb_skid_buf #(
        .W (BW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .out_valid (buf_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits)
    );

    assign out_valid = buf_valid;
    assign out_data  = out_bits[BW-1 -: WIDTH];
    assign out_rd    = out_bits[RD_W:1];
    assign out_we    = buf_valid & out_bits[0];

endmodule

`default_nettype wire

// File: tb/tb_wb_result_sel_pipe.sv
//------------------------------------------------------------------------------
// tb_wb_result_sel_pipe
// Randomised bench with a depth-2 FIFO reference model for the writeback stage.
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_result_sel_pipe;
    import wb_pkg::*;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_we, out_ready;
    logic [2:0]   in_sel;
    logic [255:0] in_data;
    logic [4:0]   in_rd;
    logic         in_ready, out_valid, out_we, sel_err;
    logic [31:0]  out_data;
    logic [4:0]   out_rd;

    logic         d6_flush, d6_in_valid, d6_in_we, d6_out_ready;
    logic [2:0]   d6_in_sel;
    logic [191:0] d6_in_data;
    logic [4:0]   d6_in_rd;
    logic         d6_in_ready, d6_out_valid, d6_out_we, d6_sel_err;
    logic [31:0]  d6_out_data;
    logic [4:0]   d6_out_rd;

    int errors = 0;
    int checks = 0;

    wb_bundle_t mq[$];
    wb_bundle_t last;

    always #5 clk = ~clk;

    wb_result_sel_pipe #(.WIDTH(32), .NUM_IN(8), .RD_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .in_rd(in_rd), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_we(out_we), .sel_err(sel_err)
    );

    wb_result_sel_pipe #(.WIDTH(32), .NUM_IN(6), .RD_W(5)) dut6 (
        .clk(clk), .rst(rst), .flush(d6_flush), .in_valid(d6_in_valid), .in_ready(d6_in_ready),
        .in_sel(d6_in_sel), .in_data(d6_in_data), .in_rd(d6_in_rd), .in_we(d6_in_we),
        .out_valid(d6_out_valid), .out_ready(d6_out_ready), .out_data(d6_out_data),
        .out_rd(d6_out_rd), .out_we(d6_out_we), .sel_err(d6_sel_err)
    );

    function automatic logic e_valid();
        return mq.size() > 0;
    endfunction

    function automatic logic e_ready();
        return mq.size() < 2;
    endfunction

    function automatic logic e_we();
        return (mq.size() > 0) && last.we;
    endfunction

    // One clock: reference FIFO of depth 2 advances alongside the DUT.
    task automatic tick();
        logic       acc, drn;
        wb_bundle_t b;
        acc    = in_valid && (mq.size() < 2);
        drn    = (mq.size() > 0) && out_ready;
        b.data = in_data[in_sel*32 +: 32];
        b.rd   = in_rd;
        b.we   = in_we;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            last = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(b);
        end
        if (mq.size() > 0) last = mq[0];
    endtask

    task automatic set_src(input int k, input logic [31:0] v);
        in_data[k*32 +: 32] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (out_rd !== 5'd0 || out_we !== 1'b0) begin errors++; $display("FAIL reset_rd_we: got %0d/%0b want 0/0", out_rd, out_we); end
        checks++; if (in_ready !== 1'b1 || sel_err !== 1'b0) begin errors++; $display("FAIL reset_ready_err: got %0b/%0b want 1/0", in_ready, sel_err); end
    endtask

    task automatic test_stream();
        set_src(RESULT_SEL_MEM, 32'hDEAD_BEEF);
        in_sel = 3'(RESULT_SEL_MEM); in_rd = 5'd5; in_we = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stream_data: got %0b/%h want 1/deadbeef", out_valid, out_data); end
        checks++; if (out_rd !== 5'd5 || out_we !== 1'b1) begin errors++; $display("FAIL stream_rd_we: got %0d/%0b want 5/1", out_rd, out_we); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_we !== 1'b0) begin errors++; $display("FAIL stream_drained: got %0b/%0b want 0/0", out_valid, out_we); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h11; exp_seq[1] = 32'h22; exp_seq[2] = 32'h33;
        set_src(RESULT_SEL_ALU, 32'h11); set_src(RESULT_SEL_PC4, 32'h22); set_src(RESULT_SEL_IMM, 32'h33);
        out_ready = 1'b0; in_valid = 1'b1; in_we = 1'b1;
        in_sel = 3'(RESULT_SEL_ALU); in_rd = 5'd1; tick();
        in_sel = 3'(RESULT_SEL_PC4); in_rd = 5'd2; tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %0b want 0", in_ready); end
        in_sel = 3'(RESULT_SEL_IMM); in_rd = 5'd3; tick();
        checks++; if (out_data !== 32'h11 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold: got %h/%0b want 11/0", out_data, in_ready); end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[i] || out_rd !== 5'(i + 1)) begin
                errors++; $display("FAIL bp_order%0d: got %0b/%h/%0d want 1/%h/%0d", i, out_valid, out_data, out_rd, exp_seq[i], i + 1);
            end
            if (i == 2) in_valid = 1'b0;
        end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_empty: got %0b/%0b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_flush();
        logic [31:0] held;
        out_ready = 1'b0; in_valid = 1'b1; in_we = 1'b1;
        set_src(RESULT_SEL_CSR, 32'h5555_0001); in_sel = 3'(RESULT_SEL_CSR); in_rd = 5'd7; tick();
        held = 32'h5555_0001;
        set_src(RESULT_SEL_AUIPC, 32'h5555_0002); in_sel = 3'(RESULT_SEL_AUIPC); tick();
        set_src(RESULT_SEL_MULDIV, 32'h5555_0003); in_sel = 3'(RESULT_SEL_MULDIV);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_we !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: got v=%0b we=%0b rdy=%0b want 0/0/1", out_valid, out_we, in_ready);
        end
        checks++; if (out_data !== held || out_rd !== 5'd7) begin errors++; $display("FAIL flush_keep: got %h/%0d want %h/7", out_data, out_rd, held); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emit%0d: got %0b want 0", i, out_valid); end
        end
    endtask

    task automatic test_out_of_range();
        logic exp_err, exp_we;
`ifdef WB_RESULT_SEL_ERR_EN
        exp_err = 1'b1; exp_we = 1'b0;
`else
        exp_err = 1'b0; exp_we = 1'b1;
`endif
        for (int k = 0; k < 6; k++) d6_in_data[k*32 +: 32] = $urandom | 32'h1;
        d6_in_sel = 3'd7; d6_in_we = 1'b1; d6_in_rd = 5'd9; d6_in_valid = 1'b1; d6_out_ready = 1'b1;
        tick();
        d6_in_valid = 1'b0;
        checks++; if (d6_out_valid !== 1'b1 || d6_out_data !== 32'h0 || d6_out_rd !== 5'd9) begin
            errors++; $display("FAIL oor_data: got %0b/%h/%0d want 1/0/9", d6_out_valid, d6_out_data, d6_out_rd);
        end
        checks++; if (d6_out_we !== exp_we || d6_sel_err !== exp_err) begin
            errors++; $display("FAIL oor_we_err: got %0b/%0b want %0b/%0b", d6_out_we, d6_sel_err, exp_we, exp_err);
        end
        tick();
        checks++; if (d6_sel_err !== exp_err || d6_out_valid !== 1'b0) begin errors++; $display("FAIL oor_sticky: got %0b/%0b want %0b/0", d6_sel_err, d6_out_valid, exp_err); end
        d6_in_sel = 3'd5; d6_in_valid = 1'b1;
        tick();
        d6_in_valid = 1'b0;
        checks++; if (d6_out_data !== d6_in_data[5*32 +: 32] || d6_out_we !== 1'b1) begin
            errors++; $display("FAIL inrange6: got %h/%0b want %h/1", d6_out_data, d6_out_we, d6_in_data[5*32 +: 32]);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [7:0] seen = '0;
        int         nsel = 0;
        for (int k = 0; k < 8; k++) set_src(k, 32'hA000_0000 + 32'(k));
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_sel    = 3'(nsel);
            in_rd     = 5'($urandom);
            in_we     = 1'($urandom);
            if (in_valid && e_ready()) begin
                seen[nsel] = 1'b1;
                nsel = (nsel + 1) % 8;
            end
            tick();
            checks++; if (out_valid !== e_valid() || in_ready !== e_ready() || out_we !== e_we()) begin
                errors++; $display("FAIL sweep_ctl c=%0d: got v=%0b r=%0b we=%0b want %0b/%0b/%0b", c, out_valid, in_ready, out_we, e_valid(), e_ready(), e_we());
            end
            if (e_valid()) begin
                checks++; if (out_data !== last.data || out_rd !== last.rd) begin
                    errors++; $display("FAIL sweep_data c=%0d: got %h/%0d want %h/%0d", c, out_data, out_rd, last.data, last.rd);
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (seen !== 8'hFF) begin errors++; $display("FAIL sweep_cover: got %b want 11111111", seen); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_we = 1'b1; in_rd = 5'd12;
        set_src(RESULT_SEL_RSVD, 32'hCAFE_F00D); in_sel = 3'(RESULT_SEL_RSVD);
        tick();
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rmid_full: got %0b/%0b want 0/1", in_ready, out_valid); end
        d6_in_sel = 3'd6; d6_in_valid = 1'b1; d6_out_ready = 1'b0;
        tick();
        d6_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_rd !== 5'd0 || out_we !== 1'b0) begin
            errors++; $display("FAIL rmid_outputs: got %0b/%h/%0d/%0b want 0/0/0/0", out_valid, out_data, out_rd, out_we);
        end
        checks++; if (in_ready !== 1'b1 || sel_err !== 1'b0 || d6_sel_err !== 1'b0) begin
            errors++; $display("FAIL rmid_ready_err: got %0b/%0b/%0b want 1/0/0", in_ready, sel_err, d6_sel_err);
        end
        checks++; if (d6_out_valid !== 1'b0 || d6_out_data !== 32'h0) begin errors++; $display("FAIL rmid_d6: got %0b/%h want 0/0", d6_out_valid, d6_out_data); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_we = 1'b0; out_ready = 1'b0;
        in_sel = '0; in_data = '0; in_rd = '0;
        d6_flush = 1'b0; d6_in_valid = 1'b0; d6_in_we = 1'b0; d6_out_ready = 1'b1;
        d6_in_sel = '0; d6_in_data = '0; d6_in_rd = '0;
        last = '0;
        for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = $urandom;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_out_of_range();
        test_sweep();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
